// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family (up and down).
package counter_pkg;

  localparam int CNT_WIDTH_DEF = 4;
  localparam int CNT_MOD_DEF   = 11;

  // Load values above the top of the sequence are clamped to mod-1.
  function automatic int unsigned clamp_ld(input int unsigned val, input int unsigned mod);
    return (val > mod - 1) ? (mod - 1) : val;
  endfunction

endpackage

// File: rtl/counter_down_if.sv
// Control/status bundle for counter_down: load and enable inputs, count and flags back.
interface counter_down_if
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
);

  // No handshake: the counter advances on every rising edge where en & clkEn is
  // high; ld overrides the advance. count/wrap are registered, bo is a decode.
  logic             en;
  logic             clkEn;
  logic             ld;
  logic [WIDTH-1:0] ldVal;
  logic [WIDTH-1:0] count;
  logic             bo;
  logic             wrap;

  modport master (
    output en, clkEn, ld, ldVal,
    input  count, bo, wrap
  );

  modport slave (
    input  en, clkEn, ld, ldVal,
    output count, bo, wrap
  );

endinterface

// File: rtl/counter_down_term_detect.sv
// Terminal-count decode: flags a counter value of zero.
module term_detect #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_val,
  output logic             o_zero
);

  assign o_zero = (i_val == '0);

endmodule

// File: rtl/counter_down.sv
// Modulo-MOD down counter: load with clamp, qualified decrement, wrap pulse and borrow-out.
module counter_down
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF,
  parameter int MOD   = CNT_MOD_DEF
) (
  input  logic           clk,
  input  logic           rst,
  counter_down_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_zero;
  logic             w_adv;

  term_detect #(.WIDTH(WIDTH)) u_term_detect (
    .i_val  (r_count),
    .o_zero (w_zero)
  );

  assign w_adv    = bus.en & bus.clkEn;
  assign w_ld_val = WIDTH'(clamp_ld(32'(bus.ldVal), MOD));

  // Load beats advance; wrap only pulses on the edge that leaves zero.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (bus.ld) begin
      w_count_nxt = w_ld_val;
    end else if (w_adv) begin
      if (w_zero) begin
        w_count_nxt = MAX_VAL;
        w_wrap_nxt  = 1'b1;
      end else begin
        w_count_nxt = r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= MAX_VAL;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.bo    = w_zero;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_counter_down.sv
// Bench for counter_down: MOD=11 and MOD=16 instances share stimulus, scoreboarded against a reference model.
module tb_counter_down;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;
  int m11;
  int m16;

  logic [5:0] exp_q11[$];
  logic [5:0] exp_q16[$];

  counter_down_if #(.WIDTH(4)) bus11 ();
  counter_down_if #(.WIDTH(4)) bus16 ();

  counter_down #(.WIDTH(4), .MOD(11)) dut11 (.clk(clk), .rst(rst), .bus(bus11.slave));
  counter_down #(.WIDTH(4), .MOD(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b0;
    bus11.en = 1'b0; bus11.clkEn = 1'b0; bus11.ld = 1'b0; bus11.ldVal = '0;
    bus16.en = 1'b0; bus16.clkEn = 1'b0; bus16.ld = 1'b0; bus16.ldVal = '0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour; returns {count, bo, wrap} after one edge.
  function automatic logic [5:0] model_next(inout int c, input int mod, input logic r,
                                            input logic e, input logic ce, input logic l,
                                            input logic [3:0] lv);
    logic w;
    w = 1'b0;
    if (r) c = mod - 1;
    else if (l) c = (int'(lv) > mod - 1) ? mod - 1 : int'(lv);
    else if (e && ce) begin
      if (c == 0) begin
        c = mod - 1;
        w = 1'b1;
      end else c = c - 1;
    end
    return {c[3:0], (c == 0), w};
  endfunction

  // driver: apply one cycle of stimulus to both counters, then score the result
  task automatic step(input logic r, input logic e, input logic ce, input logic l,
                      input logic [3:0] lv);
    logic [5:0] exp;
    rst = r;
    bus11.en = e; bus11.clkEn = ce; bus11.ld = l; bus11.ldVal = lv;
    bus16.en = e; bus16.clkEn = ce; bus16.ld = l; bus16.ldVal = lv;
    exp_q11.push_back(model_next(m11, 11, r, e, ce, l, lv));
    exp_q16.push_back(model_next(m16, 16, r, e, ce, l, lv));
    @(posedge clk);
    #1;
    exp = exp_q11.pop_front();
    check("sb11", {26'd0, bus11.count, bus11.bo, bus11.wrap}, {26'd0, exp});
    exp = exp_q16.pop_front();
    check("sb16", {26'd0, bus16.count, bus16.bo, bus16.wrap}, {26'd0, exp});
  endtask

  initial begin
    m11 = 0;
    m16 = 0;
    #1;

    // reset, then hold
    step(1, 0, 0, 0, 0);
    check("rst_count", bus11.count, 10);
    check("rst_bo", bus11.bo, 0);
    check("rst_wrap", bus11.wrap, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    check("hold_count", bus11.count, 10);

    // full countdown with wrap
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, 0);
      check("down_count", bus11.count, 32'(9 - i));
      check("down_wrap", bus11.wrap, 0);
    end
    check("zero_bo", bus11.bo, 1);
    step(0, 1, 1, 0, 0);
    check("wrap_count", bus11.count, 10);
    check("wrap_pulse", bus11.wrap, 1);
    check("wrap_bo", bus11.bo, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_single", bus11.wrap, 0);

    // clock-enable gating
    step(0, 1, 1, 0, 0); check("gate_a", bus11.count, 9);
    step(0, 1, 0, 0, 0); check("gate_b", bus11.count, 9);
    step(0, 1, 1, 0, 0); check("gate_c", bus11.count, 8);
    step(0, 1, 0, 0, 0); check("gate_d", bus11.count, 8);
    step(0, 0, 1, 0, 0); check("en_low", bus11.count, 8);

    // loads
    step(0, 1, 1, 1, 3); check("ld3", bus11.count, 3);
    step(0, 1, 1, 0, 0); check("ld3_dec", bus11.count, 2);
    step(0, 0, 0, 1, 15);
    check("ld_clamp11", bus11.count, 10);
    check("ld_noclamp16", bus16.count, 15);
    step(0, 1, 1, 1, 0);
    check("ld0_bo", bus11.bo, 1);
    check("ld0_wrap", bus11.wrap, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    check("held_zero_bo", bus11.bo, 1);

    // modulus-16 natural underflow
    step(0, 1, 1, 0, 0);
    check("m16_count", bus16.count, 15);
    check("m16_wrap", bus16.wrap, 1);
    check("m16_bo", bus16.bo, 0);

    // priority: reset over load, reset mid-count
    step(1, 1, 1, 1, 2); check("rst_over_ld", bus11.count, 10);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    check("mid_count", bus11.count, 4);
    step(1, 1, 1, 0, 0); check("rst_mid", bus11.count, 10);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
    end

    check("q11_empty", exp_q11.size(), 0);
    check("q16_empty", exp_q16.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_down.md
Name: counter_down

Overview:
- Synchronous modulo-N down counter, the counting-direction complement of the team's up counter (`counter`: count/co).
- Loads a start value, decrements on qualified enables, wraps from 0 to MOD-1 and flags terminal count with a borrow-out.
- Used as a countdown timer or divider stage: its `bo` can drive the `en`/`clkEn` of a downstream stage.
- Synthesised through the same gate-level flow: notg/nand_n/nor_n/bufg plus scan-capable dff.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 11, count modulus; sequence is MOD-1 down to 0; legal range 2..2**WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable.
- clkEn  input  1  clock-enable qualifier; the counter advances only when en & clkEn.
- ld  input  1  synchronous parallel load strobe.
- ldVal  input  WIDTH  load value.
- count  output  WIDTH  current count, registered.
- bo  output  1  borrow-out: combinational, high when count==0.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a 0->MOD-1 decrement.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: on an edge with rst=1, count<=MOD-1 and wrap<=0. bo is therefore 0 after reset (MOD>=2).
- Priority per edge: rst > ld > advance (en & clkEn) > hold.
- Load:
  - ld=1: count<=ldVal if ldVal<=MOD-1, else count<=MOD-1 (clamp).
  - wrap<=0.
  - Load ignores en/clkEn.
- Advance:
  - count!=0: count<=count-1, wrap<=0.
  - count==0: count<=MOD-1, wrap<=1.
- Hold: when en&clkEn=0 and neither rst nor ld is active, count holds and wrap<=0. wrap is never held high for more than one cycle.
- bo:
  - Pure decode of count==0, independent of en/clkEn; zero latency from count.
  - Stays high for as long as count sits at 0, including while held.
- Arithmetic:
  - Unsigned, WIDTH bits, no carry beyond WIDTH.
  - When MOD==2**WIDTH, the wrap value is all-ones and equals the natural underflow.
- Latency: one edge from qualified advance to the new count; wrap trails the 0->MOD-1 transition by 0 cycles, i.e. it registers in the same edge.
- Simultaneous events:
  - ld with advance: the load wins and no decrement is applied.
  - rst with ld: reset wins.
  - ld with ldVal=0: bo goes high the next cycle and wrap stays 0.
- Reset mid-count: takes effect on the next edge regardless of en/clkEn/ld.
- Scan: flops are standard dff cells with NbarT tied low in function mode; no scan ports at this level.
- State: implicit single-state counter; no FSM beyond the count register and the wrap flop.

Decomposition:
- Shared package `counter_pkg`:
  - CNT_WIDTH_DEF=4, CNT_MOD_DEF=11.
  - A function `clamp_ld(val, mod)` returning min(val, mod-1).
  - The up counter should reuse the same constants.
- One sub-module: `term_detect` (WIDTH param, in=count, out=zero flag). Combinational zero decode; reused for co-style decode.
- Top level: count register, next-state mux, wrap flop.

Test Plan:
- Reset, MOD=11: rst=1 for 1 edge -> count=10, bo=0, wrap=0. Hold en=0 for 3 edges -> count stays 10.
- Full countdown: en=clkEn=1 for 11 edges from 10 -> count 9..0 then 10. bo high exactly in the count==0 cycle; wrap=1 exactly one cycle after that edge, count=10.
- Gating: en=1, clkEn toggling 1,0,1,0 from count=10 -> counts 9,9,8,8. With clkEn=1, en=0 -> hold.
- Load:
  - ld=1, ldVal=3 with en=clkEn=1 -> count=3 (no decrement), next edge 2.
  - ldVal=15 -> count=10 (clamped).
  - ldVal=0 -> bo=1 next cycle, wrap=0.
- Priority: rst=1 with ld=1, ldVal=2 -> count=10. Reset at count=4 mid-run with en=1 -> count=10 next edge.
- MOD=16, WIDTH=4: from count=0 with en=clkEn=1 -> count=15, wrap=1, bo=0.
